// File: rtl/csr_file_if.sv
// csr_file_if: read/write bus between the core pipeline and csr_file.
//   master : decode/execute and writeback side. It drives read requests and
//            write-backs, and receives read responses.
//   slave  : csr_file side.
// Signals:
//   csr_re / csr_raddr / csr_wr_intent : read request. csr_wr_intent marks a
//                                        read whose instruction will also write.
//   csr_rdata / csr_rvalid / csr_illegal : registered read response.
//   csr_we / csr_waddr / csr_wdata      : write port (CSRRW/S/C result).
interface csr_file_if #(
  parameter int WIDTH = 32
);
  logic             csr_re;
  logic [11:0]      csr_raddr;
  logic             csr_wr_intent;
  logic [WIDTH-1:0] csr_rdata;
  logic             csr_rvalid;
  logic             csr_illegal;
  logic             csr_we;
  logic [11:0]      csr_waddr;
  logic [WIDTH-1:0] csr_wdata;

  modport master (
    output csr_re, csr_raddr, csr_wr_intent, csr_we, csr_waddr, csr_wdata,
    input  csr_rdata, csr_rvalid, csr_illegal
  );

  modport slave (
    input  csr_re, csr_raddr, csr_wr_intent, csr_we, csr_waddr, csr_wdata,
    output csr_rdata, csr_rvalid, csr_illegal
  );
endinterface

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file for the RV32I core.
// The file holds the trap state: mstatus (MIE/MPIE, with MPP fixed at 2'b11),
// mie, mtvec, mscratch, mepc, mcause and mtval. misa and mhartid are
// read-only constants.
// Optional feature: define CSR_COUNTERS_EN to build the 64-bit mcycle and
// minstret counters and their user-mode aliases. Without the macro, the
// counter addresses read as 0 without an illegal flag, and writes to them
// are dropped.
// Ports:
//   clk_i, rst_i          clock and asynchronous active-high reset
//   bus (slave)           read request/response and write port
//   trap_i, trap_*_i      trap entry: loads mepc/mcause/mtval and stacks MIE
//   mret_i                trap return: restores MIE from MPIE
//   retire_i              instruction retired (drives minstret)
//   mtvec_o, mepc_o       current mtvec and mepc, taken straight from the registers
//   irq_en_o              current mstatus.MIE
module csr_file #(
  parameter int               WIDTH       = 32,
  parameter int               HART_ID     = 0,
  parameter logic [WIDTH-1:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  csr_file_if.slave        bus,
  input  logic             trap_i,
  input  logic [WIDTH-1:0] trap_cause_i,
  input  logic [WIDTH-1:0] trap_pc_i,
  input  logic [WIDTH-1:0] trap_tval_i,
  input  logic             mret_i,
  input  logic             retire_i,
  output logic [WIDTH-1:0] mtvec_o,
  output logic [WIDTH-1:0] mepc_o,
  output logic             irq_en_o
);

  logic             mstatus_mie_reg;
  logic             mstatus_mpie_reg;
  logic [WIDTH-1:0] mie_reg;
  logic [WIDTH-1:0] mtvec_reg;
  logic [WIDTH-1:0] mscratch_reg;
  logic [WIDTH-1:0] mepc_reg;
  logic [WIDTH-1:0] mcause_reg;
  logic [WIDTH-1:0] mtval_reg;

  logic [WIDTH-1:0] rd_value;
  logic             rd_hit;
  logic             rd_illegal;

  // Write-port decode. Read-only and unimplemented addresses match nothing,
  // so writes to them are dropped.
  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  assign wr_mstatus  = bus.csr_we && (bus.csr_waddr == 12'h300);
  assign wr_mie      = bus.csr_we && (bus.csr_waddr == 12'h304);
  assign wr_mtvec    = bus.csr_we && (bus.csr_waddr == 12'h305);
  assign wr_mscratch = bus.csr_we && (bus.csr_waddr == 12'h340);
  assign wr_mepc     = bus.csr_we && (bus.csr_waddr == 12'h341);
  assign wr_mcause   = bus.csr_we && (bus.csr_waddr == 12'h342);
  assign wr_mtval    = bus.csr_we && (bus.csr_waddr == 12'h343);

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_reg;
  logic [63:0] minstret_reg;

  // A write to either half replaces that half. It also stalls the counter for
  // that cycle, so software sees exactly the value it wrote.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcycle_reg   <= 64'd0;
      minstret_reg <= 64'd0;
    end else begin
      if (bus.csr_we && bus.csr_waddr == 12'hB00)
        mcycle_reg[31:0] <= bus.csr_wdata;
      else if (bus.csr_we && bus.csr_waddr == 12'hB80)
        mcycle_reg[63:32] <= bus.csr_wdata;
      else
        mcycle_reg <= mcycle_reg + 64'd1;

      if (bus.csr_we && bus.csr_waddr == 12'hB02)
        minstret_reg[31:0] <= bus.csr_wdata;
      else if (bus.csr_we && bus.csr_waddr == 12'hB82)
        minstret_reg[63:32] <= bus.csr_wdata;
      else if (retire_i)
        minstret_reg <= minstret_reg + 64'd1;
    end
  end
`else
  // retire_i only drives minstret, so it has no load in this build.
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  // Combinational read mux over the current register state. A write in the
  // same cycle therefore returns the pre-write value.
  always_comb begin
    rd_value = '0;
    rd_hit   = 1'b1;
    case (bus.csr_raddr)
      12'h300: rd_value = {19'd0, 2'b11, 3'd0, mstatus_mpie_reg, 3'd0, mstatus_mie_reg, 3'd0};
      12'h301: rd_value = 32'h4000_0100;
      12'h304: rd_value = mie_reg;
      12'h305: rd_value = mtvec_reg;
      12'h340: rd_value = mscratch_reg;
      12'h341: rd_value = mepc_reg;
      12'h342: rd_value = mcause_reg;
      12'h343: rd_value = mtval_reg;
      12'hF14: rd_value = WIDTH'(HART_ID);
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: rd_value = mcycle_reg[31:0];
      12'hB80, 12'hC80: rd_value = mcycle_reg[63:32];
      12'hB02, 12'hC02: rd_value = minstret_reg[31:0];
      12'hB82, 12'hC82: rd_value = minstret_reg[63:32];
`else
      12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: rd_value = '0;
`endif
      default: rd_hit = 1'b0;
    endcase
  end

  // Addresses with [11:10]==2'b11 are read-only. This includes the counter
  // aliases even when the counters are not built.
  assign rd_illegal = !rd_hit || (bus.csr_wr_intent && bus.csr_raddr[11:10] == 2'b11);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= '0;
      mtvec_reg        <= MTVEC_RESET;
      mscratch_reg     <= '0;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      mtval_reg        <= '0;
      bus.csr_rdata    <= '0;
      bus.csr_rvalid   <= 1'b0;
      bus.csr_illegal  <= 1'b0;
    end else begin
      // Trap entry wins over MRET, and MRET wins over a CSR write.
      if (trap_i) begin
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (mret_i) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end else if (wr_mstatus) begin
        mstatus_mie_reg  <= bus.csr_wdata[3];
        mstatus_mpie_reg <= bus.csr_wdata[7];
      end

      if (wr_mie)      mie_reg      <= bus.csr_wdata;
      if (wr_mtvec)    mtvec_reg    <= {bus.csr_wdata[WIDTH-1:2], 2'b00};
      if (wr_mscratch) mscratch_reg <= bus.csr_wdata;

      if (trap_i) begin
        mepc_reg   <= {trap_pc_i[WIDTH-1:2], 2'b00};
        mcause_reg <= trap_cause_i;
        mtval_reg  <= trap_tval_i;
      end else begin
        if (wr_mepc)   mepc_reg   <= {bus.csr_wdata[WIDTH-1:2], 2'b00};
        if (wr_mcause) mcause_reg <= bus.csr_wdata;
        if (wr_mtval)  mtval_reg  <= bus.csr_wdata;
      end

      // Read response. With no request, rdata holds its last value.
      if (bus.csr_re) begin
        bus.csr_rdata   <= rd_illegal ? '0 : rd_value;
        bus.csr_rvalid  <= 1'b1;
        bus.csr_illegal <= rd_illegal;
      end else begin
        bus.csr_rvalid  <= 1'b0;
        bus.csr_illegal <= 1'b0;
      end
    end
  end

  assign mtvec_o  = mtvec_reg;
  assign mepc_o   = mepc_reg;
  assign irq_en_o = mstatus_mie_reg;

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;
  localparam logic [31:0] MTVEC_RST = 32'h0000_1000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trap_i, mret_i, retire_i;
  logic [31:0] trap_cause_i, trap_pc_i, trap_tval_i;
  logic [31:0] mtvec_o, mepc_o;
  logic        irq_en_o;

  int total = 0;
  int bad   = 0;

  csr_file_if #(.WIDTH(32)) bus ();

  csr_file #(.WIDTH(32), .HART_ID(5), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .trap_tval_i(trap_tval_i), .mret_i(mret_i), .retire_i(retire_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_en_o(irq_en_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we = 1'b1; bus.csr_waddr = a; bus.csr_wdata = d;
    step();
    bus.csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, input logic intent);
    bus.csr_re = 1'b1; bus.csr_raddr = a; bus.csr_wr_intent = intent;
    step();
    bus.csr_re = 1'b0; bus.csr_wr_intent = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    trap_i = 0; mret_i = 0; retire_i = 0;
    trap_cause_i = 0; trap_pc_i = 0; trap_tval_i = 0;
    bus.csr_re = 0; bus.csr_raddr = 0; bus.csr_wr_intent = 0;
    bus.csr_we = 0; bus.csr_waddr = 0; bus.csr_wdata = 0;

    // Values held during reset
    #3;
    check("rst_rdata",   bus.csr_rdata, 32'h0);
    check("rst_rvalid",  {31'd0, bus.csr_rvalid}, 32'h0);
    check("rst_illegal", {31'd0, bus.csr_illegal}, 32'h0);
    check("rst_mtvec",   mtvec_o, MTVEC_RST);
    check("rst_mepc",    mepc_o, 32'h0);
    check("rst_irq_en",  {31'd0, irq_en_o}, 32'h0);
    step();
    rst_i = 1'b0;

    // mstatus reset value
    csr_read(12'h300, 1'b0);
    check("mstatus_rst", bus.csr_rdata, 32'h0000_1800);
    check("rvalid_1",    {31'd0, bus.csr_rvalid}, 32'h1);
    check("illegal_0",   {31'd0, bus.csr_illegal}, 32'h0);
    step();
    check("rvalid_idle", {31'd0, bus.csr_rvalid}, 32'h0);
    check("rdata_hold",  bus.csr_rdata, 32'h0000_1800);

    // mtvec: the low two bits are forced to 0
    csr_write(12'h305, 32'h8000_0103);
    check("mtvec_o",     mtvec_o, 32'h8000_0100);
    csr_read(12'h305, 1'b0);
    check("mtvec_rd",    bus.csr_rdata, 32'h8000_0100);

    // Trap and MRET
    csr_write(12'h300, 32'h0000_0008);
    check("irq_en_set",  {31'd0, irq_en_o}, 32'h1);
    trap_i = 1; trap_cause_i = 32'hB; trap_pc_i = 32'h104; trap_tval_i = 32'h55;
    step();
    trap_i = 0;
    check("trap_mepc",   mepc_o, 32'h104);
    check("trap_irq",    {31'd0, irq_en_o}, 32'h0);
    csr_read(12'h342, 1'b0);
    check("mcause",      bus.csr_rdata, 32'hB);
    csr_read(12'h343, 1'b0);
    check("mtval",       bus.csr_rdata, 32'h55);
    csr_read(12'h300, 1'b0);
    check("mstatus_trap", bus.csr_rdata, 32'h0000_1880);
    mret_i = 1;
    step();
    mret_i = 0;
    check("mret_irq",    {31'd0, irq_en_o}, 32'h1);
    csr_read(12'h300, 1'b0);
    check("mstatus_mret", bus.csr_rdata, 32'h0000_1888);

    // A trap in the same cycle as a CSR write to mepc wins
    trap_i = 1; trap_cause_i = 32'h2; trap_pc_i = 32'h207;
    bus.csr_we = 1; bus.csr_waddr = 12'h341; bus.csr_wdata = 32'hDEAD_BEEC;
    step();
    trap_i = 0; bus.csr_we = 0;
    check("trap_vs_wr",  mepc_o, 32'h204);

    // Illegal reads and read-only registers
    csr_read(12'hF14, 1'b1);
    check("ro_illegal",  {31'd0, bus.csr_illegal}, 32'h1);
    check("ro_rdata",    bus.csr_rdata, 32'h0);
    csr_read(12'hF14, 1'b0);
    check("mhartid",     bus.csr_rdata, 32'h5);
    check("mhartid_ok",  {31'd0, bus.csr_illegal}, 32'h0);
    csr_read(12'h7C0, 1'b0);
    check("unimpl_ill",  {31'd0, bus.csr_illegal}, 32'h1);
    check("unimpl_data", bus.csr_rdata, 32'h0);
    step();
    check("illegal_clr", {31'd0, bus.csr_illegal}, 32'h0);
    csr_write(12'h301, 32'h0);
    csr_read(12'h301, 1'b0);
    check("misa_ro",     bus.csr_rdata, 32'h4000_0100);

    // A read in the same cycle as a write returns the pre-write value
    bus.csr_we = 1; bus.csr_waddr = 12'h340; bus.csr_wdata = 32'h1234_5678;
    csr_read(12'h340, 1'b0);
    bus.csr_we = 0;
    check("rd_pre_wr",   bus.csr_rdata, 32'h0);
    csr_read(12'h340, 1'b0);
    check("mscratch",    bus.csr_rdata, 32'h1234_5678);
    csr_write(12'h304, 32'hFFFF_0001);
    csr_read(12'h304, 1'b0);
    check("mie",         bus.csr_rdata, 32'hFFFF_0001);

`ifdef CSR_COUNTERS_EN
    // The write lands at edge E0 and reads capture at E1..E4. At each read the
    // counter stands one cycle further on.
    csr_write(12'hB00, 32'hFFFF_FFFE);
    csr_read(12'hB00, 1'b0);
    check("mcycle_wr",   bus.csr_rdata, 32'hFFFF_FFFE);
    csr_read(12'hB80, 1'b0);
    check("mcycleh_0",   bus.csr_rdata, 32'h0);
    csr_read(12'hB80, 1'b0);
    check("mcycleh_1",   bus.csr_rdata, 32'h1);
    csr_read(12'hB00, 1'b0);
    check("mcycle_wrap", bus.csr_rdata, 32'h1);
    retire_i = 1;
    repeat (5) step();
    retire_i = 0;
    csr_read(12'hB02, 1'b0);
    check("minstret",    bus.csr_rdata, 32'h5);
    csr_read(12'hC02, 1'b0);
    check("instret",     bus.csr_rdata, 32'h5);
    csr_read(12'hC00, 1'b1);
    check("cycle_ro",    {31'd0, bus.csr_illegal}, 32'h1);
`else
    // Counters not built: the addresses read as 0 and are still legal
    csr_write(12'hB00, 32'hFFFF_FFFE);
    csr_read(12'hB00, 1'b0);
    check("mcycle_off",  bus.csr_rdata, 32'h0);
    check("mcycle_ok",   {31'd0, bus.csr_illegal}, 32'h0);
    csr_read(12'hC82, 1'b0);
    check("instreth_ok", {31'd0, bus.csr_illegal}, 32'h0);
`endif

    // Asynchronous reset drops a pending read response
    bus.csr_re = 1; bus.csr_raddr = 12'h300;
    step();
    check("pre_rst_vld", {31'd0, bus.csr_rvalid}, 32'h1);
    #2 rst_i = 1'b1;
    #1;
    check("arst_rvalid", {31'd0, bus.csr_rvalid}, 32'h0);
    check("arst_rdata",  bus.csr_rdata, 32'h0);
    check("arst_mtvec",  mtvec_o, MTVEC_RST);
    check("arst_mepc",   mepc_o, 32'h0);
    bus.csr_re = 0;
    step();
    rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
